// File: rtl/ascon_session_arbiter.sv
// -----------------------------------------------------------------------------
// ascon_session_arbiter
//
// Shares one ascon_aead encrypt core between NUM_REQ requesters, one session
// at a time. A session runs from the owner's start pulse until the core
// reports its tag, and the owner then drops req_valid. Ownership rotates
// round-robin. A watchdog revokes a grant when the owner never starts.
//
// Ports
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   req_valid[i]        requester i asks for / holds a session
//   req_start[i]        1-cycle start pulse from requester i (owner only)
//   req_s_*             per-requester input block streams (data packed 64b/slot)
//   req_m_*             per-requester output block streams (data broadcast)
//   req_tag_valid[i]    tag-ready pulse routed to the owner
//   grant, owner_idx    one-hot owner and its index (0 when nobody owns)
//   timeout_err         1-cycle pulse when the watchdog revokes a grant
//   core_start          registered 1-cycle encrypt start to the core
//   core_busy           core still busy with previous work
//   core_s_*, core_m_*  streams to/from the core, muxed from the owner
//   core_tag_valid      tag pulse from the core, ends the session
//
// The owner index also drives the external key/nonce mux, so it is held
// stable for the whole session and only changes on entry to GRANT or on the
// return to IDLE.
// -----------------------------------------------------------------------------
module ascon_session_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int IDXW           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_start,
    input  logic [NUM_REQ-1:0]     req_s_tvalid,
    input  logic [NUM_REQ*64-1:0]  req_s_tdata,
    input  logic [NUM_REQ-1:0]     req_s_tlast,
    output logic [NUM_REQ-1:0]     req_s_tready,
    output logic [NUM_REQ-1:0]     req_m_tvalid,
    input  logic [NUM_REQ-1:0]     req_m_tready,
    output logic [63:0]            req_m_tdata,
    output logic [NUM_REQ-1:0]     req_tag_valid,

    output logic [NUM_REQ-1:0]     grant,
    output logic [IDXW-1:0]        owner_idx,
    output logic                   timeout_err,

    output logic                   core_start,
    input  logic                   core_busy,
    output logic                   core_s_tvalid,
    output logic [63:0]            core_s_tdata,
    output logic                   core_s_tlast,
    input  logic                   core_s_tready,
    input  logic                   core_m_tvalid,
    input  logic [63:0]            core_m_tdata,
    output logic                   core_m_tready,
    input  logic                   core_tag_valid
);

    // Watchdog counter wide enough to hold TIMEOUT_CYCLES-1.
    localparam int              WDW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RUN     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t              r_state;
    logic [IDXW-1:0]     r_rr_ptr;
    logic [WDW-1:0]      r_wd_cnt;
    logic [NUM_REQ-1:0]  r_grant;
    logic [IDXW-1:0]     r_owner_idx;
    logic                r_core_start;
    logic                r_timeout_err;

    logic [IDXW:0]       w_pick;
    logic                w_pick_found;
    logic [IDXW-1:0]     w_pick_idx;
    logic [NUM_REQ-1:0]  w_pick_onehot;
    logic                w_own_valid;
    logic                w_own_start;
    logic                w_run;

    // Successor of an index with explicit wrap, so non-power-of-two
    // NUM_REQ never produces an out-of-range pointer.
    function automatic logic [IDXW-1:0] f_next_idx(input logic [IDXW-1:0] idx);
        if (int'(idx) >= NUM_REQ - 1) begin
            return '0;
        end
        return idx + IDXW'(1);
    endfunction

    // Round-robin pick: first asserted request scanning ptr, ptr+1, ...
    // The scan runs backwards so the closest index to ptr overwrites the
    // others. Returns {found, index}.
    function automatic logic [IDXW:0] f_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [IDXW-1:0]    ptr);
        logic [IDXW:0] res;
        int            pos;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (valid[pos]) begin
                res = {1'b1, IDXW'(pos)};
            end
        end
        return res;
    endfunction

    assign w_pick        = f_pick(req_valid, r_rr_ptr);
    assign w_pick_found  = w_pick[IDXW];
    assign w_pick_idx    = w_pick[IDXW-1:0];
    assign w_pick_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
    assign w_own_valid   = req_valid[r_owner_idx];
    assign w_own_start   = req_start[r_owner_idx];
    assign w_run         = (r_state == S_RUN);

    // -------------------------------------------------------------------------
    // Session FSM with registered grant / start / timeout outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_wd_cnt      <= '0;
            r_grant       <= '0;
            r_owner_idx   <= '0;
            r_core_start  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_core_start  <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_wd_cnt <= '0;
                    if (w_pick_found) begin
                        r_grant     <= w_pick_onehot;
                        r_owner_idx <= w_pick_idx;
                        r_state     <= S_GRANT;
                    end
                end

                S_GRANT: begin
                    // A start that the core can accept beats both a dropped
                    // request and an expiring watchdog in the same cycle.
                    if (w_own_start && !core_busy) begin
                        r_core_start <= 1'b1;
                        r_wd_cnt     <= '0;
                        r_state      <= S_RUN;
                    end else if (!w_own_valid) begin
                        r_grant     <= '0;
                        r_owner_idx <= '0;
                        r_rr_ptr    <= f_next_idx(r_owner_idx);
                        r_wd_cnt    <= '0;
                        r_state     <= S_IDLE;
                    end else if (r_wd_cnt == WD_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_grant       <= '0;
                        r_owner_idx   <= '0;
                        r_rr_ptr      <= f_next_idx(r_owner_idx);
                        r_wd_cnt      <= '0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + WDW'(1);
                    end
                end

                S_RUN: begin
                    // A dropped req_valid here is deliberately ignored: the
                    // core is mid-message and the session must finish.
                    if (core_tag_valid) begin
                        r_state <= S_RELEASE;
                    end
                end

                S_RELEASE: begin
                    if (!w_own_valid) begin
                        r_grant     <= '0;
                        r_owner_idx <= '0;
                        r_rr_ptr    <= f_next_idx(r_owner_idx);
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign owner_idx   = r_owner_idx;
    assign core_start  = r_core_start;
    assign timeout_err = r_timeout_err;

    // -------------------------------------------------------------------------
    // Stream mux: only the owner is connected, and only while in RUN.
    // Everything else sees zeros so no non-owner can handshake with the core.
    // -------------------------------------------------------------------------
    always_comb begin
        core_s_tvalid = 1'b0;
        core_s_tdata  = '0;
        core_s_tlast  = 1'b0;
        core_m_tready = 1'b0;
        req_s_tready  = '0;
        req_m_tvalid  = '0;
        req_m_tdata   = '0;
        req_tag_valid = '0;
        if (w_run) begin
            core_s_tvalid              = req_s_tvalid[r_owner_idx];
            core_s_tdata               = req_s_tdata[{r_owner_idx, 6'd0} +: 64];
            core_s_tlast               = req_s_tlast[r_owner_idx];
            core_m_tready              = req_m_tready[r_owner_idx];
            req_s_tready[r_owner_idx]  = core_s_tready;
            req_m_tvalid[r_owner_idx]  = core_m_tvalid;
            req_m_tdata                = core_m_tdata;
            req_tag_valid[r_owner_idx] = core_tag_valid;
        end
    end

endmodule

// File: tb/tb_ascon_session_arbiter.sv
module tb_ascon_session_arbiter;

    localparam int N  = 2;
    localparam int IW = 1;
    localparam int TO = 16;
    localparam logic [63:0] ISO_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid, req_start, req_s_tvalid, req_s_tlast;
    logic [N-1:0]      req_s_tready, req_m_tvalid, req_m_tready, req_tag_valid;
    logic [N*64-1:0]   req_s_tdata;
    logic [63:0]       req_m_tdata;
    logic [N-1:0]      grant;
    logic [IW-1:0]     owner_idx;
    logic              timeout_err, core_start, core_busy;
    logic              core_s_tvalid, core_s_tlast, core_s_tready;
    logic [63:0]       core_s_tdata, core_m_tdata;
    logic              core_m_tvalid, core_m_tready, core_tag_valid;

    int n_checks = 0;
    int n_errors = 0;

    logic [64:0] exp_q[$];        // {tlast, data} expected at the core input
    int          exp_owner_q[$];  // owner expected at each core_start

    ascon_session_arbiter #(
        .NUM_REQ(N),
        .IDXW(IW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_start(req_start),
        .req_s_tvalid(req_s_tvalid), .req_s_tdata(req_s_tdata),
        .req_s_tlast(req_s_tlast), .req_s_tready(req_s_tready),
        .req_m_tvalid(req_m_tvalid), .req_m_tready(req_m_tready),
        .req_m_tdata(req_m_tdata), .req_tag_valid(req_tag_valid),
        .grant(grant), .owner_idx(owner_idx), .timeout_err(timeout_err),
        .core_start(core_start), .core_busy(core_busy),
        .core_s_tvalid(core_s_tvalid), .core_s_tdata(core_s_tdata),
        .core_s_tlast(core_s_tlast), .core_s_tready(core_s_tready),
        .core_m_tvalid(core_m_tvalid), .core_m_tdata(core_m_tdata),
        .core_m_tready(core_m_tready), .core_tag_valid(core_tag_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish (checks=%0d errors=%0d)", n_checks, n_errors);
        $fatal(1);
    end

    // Scoreboard / invariant monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [64:0] e;
        int          eo;
        if (!rst) begin
            n_checks++;
            if ($countones(grant) > 1) begin
                n_errors++;
                $display("FAIL grant_onehot: grant=%b required at most one bit", grant);
            end
            n_checks++;
            if (((req_s_tready | req_m_tvalid | req_tag_valid) & ~grant) !== '0) begin
                n_errors++;
                $display("FAIL non_owner_leak: s_tready=%b m_tvalid=%b tag=%b grant=%b required 0 outside owner",
                         req_s_tready, req_m_tvalid, req_tag_valid, grant);
            end
            if (core_s_tvalid && core_s_tready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL core_s_unexpected: got %h last=%b required no transfer", core_s_tdata, core_s_tlast);
                end else begin
                    e = exp_q.pop_front();
                    if ({core_s_tlast, core_s_tdata} !== e) begin
                        n_errors++;
                        $display("FAIL core_s_data: got last=%b data=%h required last=%b data=%h",
                                 core_s_tlast, core_s_tdata, e[64], e[63:0]);
                    end
                end
            end
            if (core_s_tvalid && core_s_tdata === ISO_DATA) begin
                n_checks++;
                n_errors++;
                $display("FAIL isolation: core_s_tdata=%h came from a non-owner", core_s_tdata);
            end
            if (core_start) begin
                n_checks++;
                if (exp_owner_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL core_start_unexpected: owner_idx=%0d required no start", owner_idx);
                end else begin
                    eo = exp_owner_q.pop_front();
                    if (int'(owner_idx) !== eo) begin
                        n_errors++;
                        $display("FAIL session_owner: got %0d required %0d", owner_idx, eo);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid      = '0;
        req_start      = '0;
        req_s_tvalid   = '0;
        req_s_tdata    = '0;
        req_s_tlast    = '0;
        req_m_tready   = '0;
        core_busy      = 1'b0;
        core_s_tready  = 1'b1;
        core_m_tvalid  = 1'b0;
        core_m_tdata   = '0;
        core_tag_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic start_pulse(input int r);
        req_start[r] = 1'b1;
        step();
        req_start[r] = 1'b0;
    endtask

    task automatic send_block(input int r, input logic [63:0] d, input logic last);
        req_s_tvalid[r]        = 1'b1;
        req_s_tdata[64*r +: 64] = d;
        req_s_tlast[r]         = last;
        exp_q.push_back({last, d});
        step();
        req_s_tvalid[r] = 1'b0;
        req_s_tlast[r]  = 1'b0;
    endtask

    task automatic tag_pulse();
        core_tag_valid = 1'b1;
        step();
        core_tag_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        req_valid    = 2'b11;
        req_s_tvalid = 2'b11;
        step();
        step();
        n_checks++;
        if (grant !== 2'b00) begin n_errors++; $display("FAIL reset_grant: got %b required 00", grant); end
        n_checks++;
        if (owner_idx !== 1'b0) begin n_errors++; $display("FAIL reset_owner: got %0d required 0", owner_idx); end
        n_checks++;
        if ({core_start, timeout_err} !== 2'b00) begin n_errors++; $display("FAIL reset_pulses: start=%b timeout=%b required 0 0", core_start, timeout_err); end
        n_checks++;
        if ({core_s_tvalid, core_m_tready, req_s_tready, req_m_tvalid} !== '0) begin
            n_errors++;
            $display("FAIL reset_streams: core_s_tvalid=%b core_m_tready=%b s_tready=%b m_tvalid=%b required all 0",
                     core_s_tvalid, core_m_tready, req_s_tready, req_m_tvalid);
        end
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_single_session();
        do_reset();
        req_valid = 2'b01;
        #1;
        n_checks++;
        if (grant !== 2'b00) begin n_errors++; $display("FAIL single_grant_early: got %b required 00", grant); end
        step();
        n_checks++;
        if (grant !== 2'b01) begin n_errors++; $display("FAIL single_grant: got %b required 01", grant); end
        exp_owner_q.push_back(0);
        start_pulse(0);
        n_checks++;
        if (core_start !== 1'b1) begin n_errors++; $display("FAIL single_core_start: got %b required 1", core_start); end
        step();
        n_checks++;
        if (core_start !== 1'b0) begin n_errors++; $display("FAIL single_core_start_width: got %b required 0", core_start); end
        send_block(0, 64'h0123_4567_89AB_CDEF, 1'b0);
        send_block(0, 64'hFEDC_BA98_7654_3210, 1'b1);
        core_m_tvalid = 1'b1;
        core_m_tdata  = 64'h1122_3344_5566_7788;
        req_m_tready  = 2'b01;
        #1;
        n_checks++;
        if ({req_m_tvalid, core_m_tready} !== 3'b011) begin
            n_errors++;
            $display("FAIL single_out_stream: m_tvalid=%b core_m_tready=%b required 01 1", req_m_tvalid, core_m_tready);
        end
        n_checks++;
        if (req_m_tdata !== 64'h1122_3344_5566_7788) begin n_errors++; $display("FAIL single_out_data: got %h required 1122334455667788", req_m_tdata); end
        core_m_tvalid  = 1'b0;
        req_m_tready   = 2'b00;
        core_tag_valid = 1'b1;
        #1;
        n_checks++;
        if (req_tag_valid !== 2'b01) begin n_errors++; $display("FAIL single_tag: got %b required 01", req_tag_valid); end
        step();
        core_tag_valid  = 1'b0;
        req_s_tvalid[0] = 1'b1;
        req_m_tready    = 2'b01;
        #1;
        n_checks++;
        if ({core_s_tvalid, core_m_tready, grant} !== 4'b0001) begin
            n_errors++;
            $display("FAIL release_gating: core_s_tvalid=%b core_m_tready=%b grant=%b required 0 0 01",
                     core_s_tvalid, core_m_tready, grant);
        end
        req_s_tvalid = '0;
        req_m_tready = '0;
        req_valid    = 2'b00;
        step();
        n_checks++;
        if ({grant, owner_idx} !== 3'b000) begin n_errors++; $display("FAIL single_release: grant=%b owner=%0d required 00 0", grant, owner_idx); end
    endtask

    task automatic test_contention();
        logic [N-1:0] eg;
        int           w;
        int           o;
        do_reset();
        req_valid = 2'b11;
        for (int s = 0; s < 4; s++) begin
            o = s % 2;
            w = 0;
            while (grant === 2'b00 && w < 8) begin
                step();
                w++;
            end
            eg    = '0;
            eg[o] = 1'b1;
            n_checks++;
            if (grant !== eg) begin n_errors++; $display("FAIL contention_grant[%0d]: got %b required %b", s, grant, eg); end
            exp_owner_q.push_back(o);
            start_pulse(o);
            send_block(o, {32'hC0DE_0000 + 32'(s), 32'h5A5A_0000 + 32'(o)}, 1'b1);
            tag_pulse();
            req_valid[o] = 1'b0;
            step();
            n_checks++;
            if (grant !== 2'b00) begin n_errors++; $display("FAIL contention_gap[%0d]: got %b required 00", s, grant); end
            req_valid[o] = 1'b1;
        end
        req_valid = 2'b00;
        step();
        step();
    endtask

    task automatic test_isolation();
        do_reset();
        req_s_tvalid[1]       = 1'b1;
        req_s_tdata[127:64]   = ISO_DATA;
        req_valid             = 2'b01;
        step();
        n_checks++;
        if (grant !== 2'b01) begin n_errors++; $display("FAIL iso_grant: got %b required 01", grant); end
        start_pulse(1);
        n_checks++;
        if (core_start !== 1'b0) begin n_errors++; $display("FAIL iso_foreign_start: got %b required 0", core_start); end
        exp_owner_q.push_back(0);
        start_pulse(0);
        send_block(0, 64'hA5A5_0000_0000_0001, 1'b0);
        n_checks++;
        if (req_s_tready !== 2'b01) begin n_errors++; $display("FAIL iso_s_tready: got %b required 01", req_s_tready); end
        core_m_tvalid = 1'b1;
        req_m_tready  = 2'b11;
        #1;
        n_checks++;
        if (req_m_tvalid !== 2'b01) begin n_errors++; $display("FAIL iso_m_tvalid: got %b required 01", req_m_tvalid); end
        core_m_tvalid = 1'b0;
        req_m_tready  = 2'b00;
        send_block(0, 64'hA5A5_0000_0000_0002, 1'b1);
        tag_pulse();
        req_s_tvalid = '0;
        req_valid    = 2'b00;
        step();
    endtask

    task automatic test_watchdog();
        int n;
        do_reset();
        req_valid = 2'b10;
        step();
        n_checks++;
        if (grant !== 2'b10) begin n_errors++; $display("FAIL wd_grant: got %b required 10", grant); end
        n = 0;
        while (timeout_err !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        n_checks++;
        if (n !== TO) begin n_errors++; $display("FAIL wd_cycles: got %0d required %0d", n, TO); end
        n_checks++;
        if (grant !== 2'b00) begin n_errors++; $display("FAIL wd_revoke: got %b required 00", grant); end
        req_valid = 2'b11;
        step();
        n_checks++;
        if ({grant, timeout_err} !== 3'b010) begin
            n_errors++;
            $display("FAIL wd_next_pick: grant=%b timeout_err=%b required 01 0", grant, timeout_err);
        end
        req_valid = 2'b00;
        step();
        step();
    endtask

    task automatic test_busy_start();
        do_reset();
        req_valid = 2'b01;
        step();
        core_busy = 1'b1;
        start_pulse(0);
        n_checks++;
        if ({core_start, grant} !== 3'b001) begin
            n_errors++;
            $display("FAIL busy_ignored: core_start=%b grant=%b required 0 01", core_start, grant);
        end
        step();
        core_busy = 1'b0;
        step();
        n_checks++;
        if (core_start !== 1'b0) begin n_errors++; $display("FAIL busy_no_replay: got %b required 0", core_start); end
        exp_owner_q.push_back(0);
        start_pulse(0);
        n_checks++;
        if (core_start !== 1'b1) begin n_errors++; $display("FAIL busy_repulse: got %b required 1", core_start); end
        tag_pulse();
        req_valid = 2'b00;
        step();
        n_checks++;
        if (grant !== 2'b00) begin n_errors++; $display("FAIL busy_release: got %b required 00", grant); end
    endtask

    task automatic test_reset_in_run();
        do_reset();
        req_valid = 2'b01;
        step();
        start_pulse(0);
        req_s_tvalid[0]     = 1'b1;
        req_s_tdata[63:0]   = 64'h0BAD_F00D_0BAD_F00D;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({grant, core_start, core_s_tvalid} !== 4'b0000) begin
            n_errors++;
            $display("FAIL rst_in_run: grant=%b core_start=%b core_s_tvalid=%b required 00 0 0",
                     grant, core_start, core_s_tvalid);
        end
        req_s_tvalid = '0;
        req_valid    = 2'b10;
        step();
        rst = 1'b0;
        step();
        n_checks++;
        if ({grant, owner_idx} !== 3'b101) begin n_errors++; $display("FAIL rst_regrant: grant=%b owner=%0d required 10 1", grant, owner_idx); end
        req_valid = 2'b00;
        step();
        step();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_session();
        test_contention();
        test_isolation();
        test_watchdog();
        test_busy_start();
        test_reset_in_run();
        n_checks++;
        if (exp_q.size() != 0 || exp_owner_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d blocks and %0d starts left required 0 0", exp_q.size(), exp_owner_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
